load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 46 ++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access size encoding, FSM states,
// byte-enable base patterns and the word-boundary crossing test.
package lsu_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10
  } mem_type_t;

  typedef enum logic [1:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StResp
  } lsu_state_t;

  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

  // Encoding 2'b11 is folded into a word access.
  function automatic mem_type_t norm_type(logic [1:0] t);
    mem_type_t r;
    case (t)
      2'b01:   r = MEM_BYTE;
      2'b10:   r = MEM_HALF;
      default: r = MEM_WORD;
    endcase
    return r;
  endfunction

  function automatic logic crosses(logic [1:0] off, mem_type_t t);
    return ((t == MEM_HALF) && (off == 2'd3)) || ((t == MEM_WORD) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and store-data shift per bus phase,
// and load-data extraction/extension from one or two bus words.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  mem_type_t   mem_type_i,
  input  logic        zext_i,
  input  logic        hi_phase_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_lo_i,
  input  logic [31:0] rdata_hi_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [3:0]  be_base;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] rd_word;

  always_comb begin
    be_base = BeWord;
    case (mem_type_i)
      MEM_BYTE: be_base = BeByte;
      MEM_HALF: be_base = BeHalf;
      default:  be_base = BeWord;
    endcase

    // Upper halves of the wide vectors hold the lanes spilling into the next word.
    be_wide = {4'b0000, be_base} << off_i;
    wd_wide = {32'd0, wdata_i} << {off_i, 3'b000};
    rd_word = 32'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});

    be_o    = hi_phase_i ? be_wide[7:4] : be_wide[3:0];
    wdata_o = hi_phase_i ? wd_wide[63:32] : wd_wide[31:0];

    case (mem_type_i)
      MEM_BYTE: load_o = zext_i ? {24'd0, rd_word[7:0]} : {{24{rd_word[7]}}, rd_word[7:0]};
      MEM_HALF: load_o = zext_i ? {16'd0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
      default:  load_o = rd_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding core request to a simple req/ack bus.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses into two bus beats.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic [1:0]  memType_i,
  input  logic        memSign_i,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        busy_o,
  output logic        bus_req_o,
  input  logic        bus_ack_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, sign_q;
  logic        misalign_q, misalign_d;
  mem_type_t   type_q;

  logic        handshake;
  logic        in_acc, hi_phase;
  logic [29:0] word_addr;
  logic [3:0]  align_be;
  logic [31:0] align_wdata, align_load, rdata_lo;

  assign handshake = req_valid_i && req_ready_o;
  assign in_acc    = (state_q == StAcc0) || (state_q == StAcc1);
  assign hi_phase  = (state_q == StAcc1);

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [31:0] lo_q, lo_d;
  logic        cur_cross;

  assign cur_cross = crosses(addr_q[1:0], type_q);
  assign rdata_lo  = hi_phase ? lo_q : bus_rdata_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lo_q <= 32'd0;
    else          lo_q <= lo_d;
  end
`else
  logic req_cross;

  assign req_cross = crosses(addr_i[1:0], norm_type(memType_i));
  assign rdata_lo  = bus_rdata_i;
`endif

  lsu_align u_align (
    .off_i      (addr_q[1:0]),
    .mem_type_i (type_q),
    .zext_i     (sign_q),
    .hi_phase_i (hi_phase),
    .wdata_i    (wdata_q),
    .rdata_lo_i (rdata_lo),
    .rdata_hi_i (bus_rdata_i),
    .be_o       (align_be),
    .wdata_o    (align_wdata),
    .load_o     (align_load)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      type_q  <= MEM_WORD;
    end else if (handshake) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      we_q    <= we_i;
      sign_q  <= memSign_i;
      type_q  <= norm_type(memType_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      rdata_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    lo_d       = lo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          misalign_d = 1'b0;
          state_d    = StAcc0;
`ifndef LSU_MISALIGNED_SPLIT_EN
          // Rejected accesses never touch the bus.
          if (req_cross) begin
            misalign_d = 1'b1;
            state_d    = StResp;
          end
`endif
        end
      end
      StAcc0: begin
        if (bus_ack_i) begin
          state_d = StResp;
          if (!we_q) rdata_d = align_load;
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (cur_cross) begin
            state_d = StAcc1;
            rdata_d = rdata_q;
            lo_d    = bus_rdata_i;
          end
`endif
        end
      end
      StAcc1: begin
        if (bus_ack_i) begin
          state_d = StResp;
          if (!we_q) rdata_d = align_load;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign word_addr = addr_q[31:2] + {29'd0, hi_phase};

  always_comb begin
    req_ready_o = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    rsp_valid_o = (state_q == StResp);
    misalign_o  = (state_q == StResp) && misalign_q;
    rdata_o     = rdata_q;
    bus_req_o   = in_acc;
    bus_we_o    = in_acc && we_q;
    bus_addr_o  = in_acc ? {word_addr, 2'b00} : 32'd0;
    bus_be_o    = in_acc ? align_be : 4'd0;
    bus_wdata_o = in_acc ? align_wdata : 32'd0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a wait-state bus responder.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, we, sign;
  logic [1:0]  mtype;
  logic [31:0] addr, wdata;
  logic        rsp_valid, misalign, busy;
  logic [31:0] rdata;
  logic        bus_req, bus_ack, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        resp_ack = 1'b0;
  logic        late_ack = 1'b0;

  assign bus_ack = resp_ack | late_ack;

  load_store_unit dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .we_i        (we),
    .memType_i   (mtype),
    .memSign_i   (sign),
    .rsp_valid_o (rsp_valid),
    .rdata_o     (rdata),
    .misalign_o  (misalign),
    .busy_o      (busy),
    .bus_req_o   (bus_req),
    .bus_ack_i   (bus_ack),
    .bus_addr_o  (bus_addr),
    .bus_we_o    (bus_we),
    .bus_be_o    (bus_be),
    .bus_wdata_o (bus_wdata),
    .bus_rdata_i (bus_rdata)
  );

  always #5 clk = ~clk;

  // Bus responder: acks after ack_delay wait cycles and logs every accepted beat.
  logic [31:0] mem [logic [31:0]];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          tx_total  = 0;
  logic [31:0] log_addr [16];
  logic [31:0] log_wd   [16];
  logic [3:0]  log_be   [16];
  logic        log_we   [16];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (32'hDEAD0000 ^ a);
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus_req) begin
      if (wait_cnt >= ack_delay) begin
        resp_ack = 1'b1;
        bus_rdata = mem_rd(bus_addr);
        log_addr[tx_total % 16] = bus_addr;
        log_wd[tx_total % 16]   = bus_wdata;
        log_be[tx_total % 16]   = bus_be;
        log_we[tx_total % 16]   = bus_we;
        tx_total++;
        wait_cnt = 0;
      end else begin
        resp_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  mtype;
    logic        sign;
    int          delay;
    logic [31:0] mem0;
    logic [31:0] mem1;
    int          exp_ntx;
    logic [3:0]  exp_be0;
    logic [3:0]  exp_be1;
    logic [31:0] exp_wd0;
    logic [31:0] exp_wd1;
    int          exp_lat;
    logic        exp_mis;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic w,
                              input logic [1:0] t, input logic s, input int d,
                              input logic [31:0] m0, input logic [31:0] m1, input int ntx,
                              input logic [3:0] be0, input logic [3:0] be1,
                              input logic [31:0] wd0, input logic [31:0] wd1, input int lat,
                              input logic mis, input logic [31:0] rd);
    vec_t v;
    v.addr = a; v.wdata = wd; v.we = w; v.mtype = t; v.sign = s; v.delay = d;
    v.mem0 = m0; v.mem1 = m1; v.exp_ntx = ntx; v.exp_be0 = be0; v.exp_be1 = be1;
    v.exp_wd0 = wd0; v.exp_wd1 = wd1; v.exp_lat = lat; v.exp_mis = mis; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    int          base;
    int          ntx;
    logic        seen;
    logic [31:0] wa;
    wa = {v.addr[31:2], 2'b00};
    @(negedge clk);
    mem[wa]      = v.mem0;
    mem[wa + 4]  = v.mem1;
    ack_delay    = v.delay;
    check($sformatf("v%0d ready", idx), {31'd0, req_ready}, 32'd1);
    base      = tx_total;
    addr      = v.addr;
    wdata     = v.wdata;
    we        = v.we;
    mtype     = v.mtype;
    sign      = v.sign;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 50) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1'b1;
    end
    ntx = tx_total - base;
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d misalign", idx), {31'd0, misalign}, {31'd0, v.exp_mis});
    check($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
    check($sformatf("v%0d bus beats", idx), ntx, v.exp_ntx);
    if (v.exp_ntx >= 1 && ntx >= 1) begin
      check($sformatf("v%0d addr0", idx), log_addr[base % 16], wa);
      check($sformatf("v%0d be0", idx), {28'd0, log_be[base % 16]}, {28'd0, v.exp_be0});
      check($sformatf("v%0d we0", idx), {31'd0, log_we[base % 16]}, {31'd0, v.we});
      if (v.we) check($sformatf("v%0d wdata0", idx), log_wd[base % 16], v.exp_wd0);
    end
    if (v.exp_ntx >= 2 && ntx >= 2) begin
      check($sformatf("v%0d addr1", idx), log_addr[(base + 1) % 16], wa + 4);
      check($sformatf("v%0d be1", idx), {28'd0, log_be[(base + 1) % 16]}, {28'd0, v.exp_be1});
      if (v.we) check($sformatf("v%0d wdata1", idx), log_wd[(base + 1) % 16], v.exp_wd1);
    end
  endtask

  initial begin
    int base;
    int cyc;
    int req_cycles;

    rst_n = 1'b1; req_valid = 1'b0; addr = '0; wdata = '0; we = 1'b0; mtype = '0;
    sign = 1'b0; bus_rdata = '0;
    #3 rst_n = 1'b0;
    #1;
    check("reset flags", {26'd0, req_ready, busy, bus_req, rsp_valid, misalign, bus_we},
          32'b100000);
    check("reset bus_be", {28'd0, bus_be}, 32'd0);
    check("reset bus_addr", bus_addr, 32'd0);
    check("reset bus_wdata", bus_wdata, 32'd0);
    check("reset rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //         addr          wdata         we    type   sg d  mem0          mem1          ntx be0     be1     wd0           wd1           lat mis rdata
    vecs.push_back(mk(32'h103, 32'h0, 1'b0, 2'b01, 1'b0, 0, 32'h80123456, 32'h0, 1, 4'b1000, 4'h0, 32'h0, 32'h0, 2, 1'b0, 32'hFFFFFF80));
    vecs.push_back(mk(32'h103, 32'h0, 1'b0, 2'b01, 1'b1, 0, 32'h80123456, 32'h0, 1, 4'b1000, 4'h0, 32'h0, 32'h0, 2, 1'b0, 32'h00000080));
    vecs.push_back(mk(32'h102, 32'h0, 1'b0, 2'b10, 1'b0, 0, 32'h9ABC1234, 32'h0, 1, 4'b1100, 4'h0, 32'h0, 32'h0, 2, 1'b0, 32'hFFFF9ABC));
    vecs.push_back(mk(32'h101, 32'h0, 1'b0, 2'b10, 1'b1, 0, 32'h11F00D22, 32'h0, 1, 4'b0110, 4'h0, 32'h0, 32'h0, 2, 1'b0, 32'h0000F00D));
    vecs.push_back(mk(32'h200, 32'h0, 1'b0, 2'b00, 1'b0, 0, 32'hCAFEBABE, 32'h0, 1, 4'b1111, 4'h0, 32'h0, 32'h0, 2, 1'b0, 32'hCAFEBABE));
    vecs.push_back(mk(32'h301, 32'hA5, 1'b1, 2'b01, 1'b0, 0, 32'h0, 32'h0, 1, 4'b0010, 4'h0, 32'h0000A500, 32'h0, 2, 1'b0, 32'hCAFEBABE));
    vecs.push_back(mk(32'h204, 32'h0, 1'b0, 2'b11, 1'b0, 0, 32'h01020304, 32'h0, 1, 4'b1111, 4'h0, 32'h0, 32'h0, 2, 1'b0, 32'h01020304));
    vecs.push_back(mk(32'h100, 32'h0, 1'b0, 2'b01, 1'b0, 0, 32'h0000007F, 32'h0, 1, 4'b0001, 4'h0, 32'h0, 32'h0, 2, 1'b0, 32'h0000007F));
    vecs.push_back(mk(32'h400, 32'h12345678, 1'b1, 2'b00, 1'b0, 1, 32'h0, 32'h0, 1, 4'b1111, 4'h0, 32'h12345678, 32'h0, 3, 1'b0, 32'h0000007F));
    vecs.push_back(mk(32'h102, 32'h0, 1'b0, 2'b10, 1'b0, 2, 32'h7FFF0000, 32'h0, 1, 4'b1100, 4'h0, 32'h0, 32'h0, 4, 1'b0, 32'h00007FFF));
    vecs.push_back(mk(32'h501, 32'hFFFF1234, 1'b1, 2'b10, 1'b0, 0, 32'h0, 32'h0, 1, 4'b0110, 4'h0, 32'hFF123400, 32'h0, 2, 1'b0, 32'h00007FFF));
`ifdef LSU_MISALIGNED_SPLIT_EN
    vecs.push_back(mk(32'h101, 32'h0, 1'b0, 2'b00, 1'b0, 0, 32'h44332211, 32'h88776655, 2, 4'b1110, 4'b0001, 32'h0, 32'h0, 3, 1'b0, 32'h55443322));
    vecs.push_back(mk(32'h103, 32'h0, 1'b0, 2'b10, 1'b0, 0, 32'h44332211, 32'h88776655, 2, 4'b1000, 4'b0001, 32'h0, 32'h0, 3, 1'b0, 32'h00005544));
    vecs.push_back(mk(32'h102, 32'hAABBCCDD, 1'b1, 2'b00, 1'b0, 0, 32'h0, 32'h0, 2, 4'b1100, 4'b0011, 32'hCCDD0000, 32'h0000AABB, 3, 1'b0, 32'h00005544));
`else
    vecs.push_back(mk(32'h101, 32'h0, 1'b0, 2'b00, 1'b0, 0, 32'h44332211, 32'h88776655, 0, 4'h0, 4'h0, 32'h0, 32'h0, 1, 1'b1, 32'h00007FFF));
    vecs.push_back(mk(32'h103, 32'h0, 1'b0, 2'b10, 1'b0, 0, 32'h44332211, 32'h88776655, 0, 4'h0, 4'h0, 32'h0, 32'h0, 1, 1'b1, 32'h00007FFF));
    vecs.push_back(mk(32'h102, 32'hAABBCCDD, 1'b1, 2'b00, 1'b0, 0, 32'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 1, 1'b1, 32'h00007FFF));
`endif

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Delayed-ack store: bus outputs must hold while waiting; requests while busy are dropped.
    @(negedge clk);
    ack_delay = 3;
    base      = tx_total;
    addr = 32'h202; wdata = 32'h0000BEEF; we = 1'b1; mtype = 2'b10; sign = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 addr = 32'h300;
    cyc = 0;
    req_cycles = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) break;
      req_cycles++;
      check("stall busy", {31'd0, busy}, 32'd1);
      check("stall bus_req", {31'd0, bus_req}, 32'd1);
      check("stall bus_addr", bus_addr, 32'h200);
      check("stall bus_be", {28'd0, bus_be}, 32'b1100);
      check("stall bus_wdata", bus_wdata, 32'hBEEF0000);
      check("stall bus_we", {31'd0, bus_we}, 32'd1);
    end
    req_valid = 1'b0;
    check("stall req cycles", req_cycles, 4);
    check("stall latency", cyc, 5);
    check("stall beats", tx_total - base, 1);
    @(negedge clk);
    check("stall back idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a pending bus access, followed by a stray ack.
    ack_delay = 1000;
    addr = 32'h100; wdata = 32'h0; we = 1'b0; mtype = 2'b00; sign = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort in acc0", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort bus_req", {31'd0, bus_req}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort ready", {31'd0, req_ready}, 32'd1);
    check("abort bus_be", {28'd0, bus_be}, 32'd0);
    check("abort rdata", rdata, 32'd0);
    @(negedge clk);
    late_ack = 1'b1;
    rst_n    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late ack rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("late ack busy", {31'd0, busy}, 32'd0);
    end
    late_ack  = 1'b0;
    ack_delay = 0;
    check("after abort ready", {31'd0, req_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
